// File: rtl/matrix_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_load_pkg
// Description : Shared constants, state encoding and default element width
//               for the matrix load block and its index decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_load_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int ELEM_CNT       = 16;
  localparam int IDX_W          = 4;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/load_index_decoder_module.sv
`default_nettype none
// ============================================================================
// Module      : load_index_decoder_module
// Description : Turns the fill index plus a write strobe into 16 one-hot
//               element write enables. Bit n of wr_en targets the element at
//               row-major position n (0 -> a11, 1 -> a12, ..., 15 -> a44).
//               Build option MATRIX_LOAD_COL_MAJOR_EN: column-major fill
//               order, obtained by swapping the two index halves.
// Revision    : 1.0 - initial release
// ============================================================================
module load_index_decoder_module
  import matrix_load_pkg::*;
(
  input  logic [IDX_W-1:0]    idx,
  input  logic                wr_stb,
  output logic [ELEM_CNT-1:0] wr_en
);

  logic [IDX_W-1:0] w_idx_eff;

`ifdef MATRIX_LOAD_COL_MAJOR_EN
  // Low half of the index selects the row, high half the column.
  assign w_idx_eff = {idx[1:0], idx[3:2]};
`else
  assign w_idx_eff = idx;
`endif

  // One-hot enable for the addressed element, only while strobed.
  always_comb begin
    wr_en = '0;
    if (wr_stb) begin
      wr_en[w_idx_eff] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_load_module.sv
`default_nettype none
// ============================================================================
// Module      : matrix_load_module
// Description : Fills a 4x4 register bank from a valid/ready byte stream,
//               raises mat_valid when all 16 elements are loaded and holds
//               the bank stable until mat_ack. Fill order is row-major, or
//               column-major when MATRIX_LOAD_COL_MAJOR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_load_module
  import matrix_load_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mat_ack,
  output logic              mat_valid,
  output logic [4:0]        load_count,
  output logic [DATA_W-1:0] a11, a12, a13, a14,
  output logic [DATA_W-1:0] a21, a22, a23, a24,
  output logic [DATA_W-1:0] a31, a32, a33, a34,
  output logic [DATA_W-1:0] a41, a42, a43, a44
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(ELEM_CNT - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_index;
  logic [4:0]          r_load_count;
  logic                r_mat_valid;
  logic [DATA_W-1:0]   r_mat [ELEM_CNT];
  logic                w_xfer;
  logic [ELEM_CNT-1:0] w_wr_en;

  // Accept only while filling; a pending clear blocks the byte so none is lost.
  assign in_ready = (r_state == ST_FILL) && !clear;
  assign w_xfer   = in_valid && in_ready;

  load_index_decoder_module u_decoder (
    .idx    (r_index),
    .wr_stb (w_xfer),
    .wr_en  (w_wr_en)
  );

  // Fill/full control: index, element count and the matrix-valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FILL;
      r_index      <= '0;
      r_load_count <= '0;
      r_mat_valid  <= 1'b0;
    end else if (clear) begin
      r_state      <= ST_FILL;
      r_index      <= '0;
      r_load_count <= '0;
      r_mat_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_xfer) begin
            r_load_count <= r_load_count + 5'd1;
            if (r_index == C_LAST_IDX) begin
              // Index parks at 15; only ack or clear starts a new fill.
              r_state     <= ST_FULL;
              r_mat_valid <= 1'b1;
            end else begin
              r_index <= r_index + 4'd1;
            end
          end
        end
        ST_FULL: begin
          if (mat_ack) begin
            r_state      <= ST_FILL;
            r_index      <= '0;
            r_load_count <= '0;
            r_mat_valid  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  // Element bank: zeroed by reset/clear, otherwise written on its enable.
  generate
    for (genvar gi = 0; gi < ELEM_CNT; gi++) begin : g_elem
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_mat[gi] <= '0;
        end else if (clear) begin
          r_mat[gi] <= '0;
        end else if (w_wr_en[gi]) begin
          r_mat[gi] <= in_data;
        end
      end
    end
  endgenerate

  assign mat_valid  = r_mat_valid;
  assign load_count = r_load_count;

  assign a11 = r_mat[0];
  assign a12 = r_mat[1];
  assign a13 = r_mat[2];
  assign a14 = r_mat[3];
  assign a21 = r_mat[4];
  assign a22 = r_mat[5];
  assign a23 = r_mat[6];
  assign a24 = r_mat[7];
  assign a31 = r_mat[8];
  assign a32 = r_mat[9];
  assign a33 = r_mat[10];
  assign a34 = r_mat[11];
  assign a41 = r_mat[12];
  assign a42 = r_mat[13];
  assign a43 = r_mat[14];
  assign a44 = r_mat[15];

endmodule
`default_nettype wire

// File: tb/tb_matrix_load_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_load_module
// Description : Directed self-checking bench for matrix_load_module.
//               Fill-order expectations follow MATRIX_LOAD_COL_MAJOR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_load_module;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mat_ack = 1'b0;
  logic       mat_valid;
  logic [4:0] load_count;
  logic [7:0] a [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_load_module #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mat_ack(mat_ack), .mat_valid(mat_valid), .load_count(load_count),
    .a11(a[0]),  .a12(a[1]),  .a13(a[2]),  .a14(a[3]),
    .a21(a[4]),  .a22(a[5]),  .a23(a[6]),  .a24(a[7]),
    .a31(a[8]),  .a32(a[9]),  .a33(a[10]), .a34(a[11]),
    .a41(a[12]), .a42(a[13]), .a43(a[14]), .a44(a[15])
  );

  // Row-major element position written by the k-th accepted byte.
  function automatic int pos(input int k);
`ifdef MATRIX_LOAD_COL_MAJOR_EN
    return (k % 4) * 4 + k / 4;
`else
    return k;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (mat_valid !== 1'b0 || load_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: mat_valid=%b load_count=%0d, required 0/0", mat_valid, load_count);
    end
    for (int p = 0; p < 16; p++) begin
      checks++;
      if (a[p] !== 8'h00) begin
        errors++;
        $display("FAIL reset_a%0d%0d: got %h, required 00", p/4+1, p%4+1, a[p]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      if (k == 15) begin
        checks++;
        if (mat_valid !== 1'b0 || load_count !== 5'd15) begin
          errors++;
          $display("FAIL fill_pre16: mat_valid=%b load_count=%0d, required 0/15", mat_valid, load_count);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (mat_valid !== 1'b1 || load_count !== 5'd16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_done: mat_valid=%b load_count=%0d in_ready=%b, required 1/16/0",
               mat_valid, load_count, in_ready);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (a[pos(k)] !== 8'(k + 1)) begin
        errors++;
        $display("FAIL fill_a%0d%0d: got %h, required %h", pos(k)/4+1, pos(k)%4+1, a[pos(k)], 8'(k + 1));
      end
    end
  endtask

  task automatic test_full_hold_and_ack();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (a[pos(k)] !== 8'(k + 1)) begin
        errors++;
        $display("FAIL hold_a%0d%0d: got %h, required %h", pos(k)/4+1, pos(k)%4+1, a[pos(k)], 8'(k + 1));
      end
    end
    checks++;
    if (mat_valid !== 1'b1 || load_count !== 5'd16) begin
      errors++;
      $display("FAIL hold_ctrl: mat_valid=%b load_count=%0d, required 1/16", mat_valid, load_count);
    end
    mat_ack = 1'b1;
    tick();
    mat_ack = 1'b0;
    checks++;
    if (mat_valid !== 1'b0 || load_count !== 5'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_ctrl: mat_valid=%b load_count=%0d in_ready=%b, required 0/0/1",
               mat_valid, load_count, in_ready);
    end
    checks++;
    if (a[pos(0)] !== 8'h01) begin
      errors++;
      $display("FAIL ack_retain: got %h, required 01", a[pos(0)]);
    end
    // Back-to-back: byte in the cycle right after the ack edge.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a[pos(0)] !== 8'hAA || a[pos(1)] !== 8'h02 || load_count !== 5'd1) begin
      errors++;
      $display("FAIL back_to_back: first=%h second=%h load_count=%0d, required AA/02/1",
               a[pos(0)], a[pos(1)], load_count);
    end
  endtask

  task automatic test_gapped();
    int n;
    n = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + k);
      tick();
      n++;
      in_valid = 1'b0;
      in_data  = 8'hEE;
      checks++;
      if (load_count !== 5'(n)) begin
        errors++;
        $display("FAIL gap_count_xfer: got %0d, required %0d", load_count, n);
      end
      if (k < 15) begin
        tick();
        tick();
        checks++;
        if (load_count !== 5'(n)) begin
          errors++;
          $display("FAIL gap_count_idle: got %0d, required %0d", load_count, n);
        end
      end
    end
    checks++;
    if (mat_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_mat_valid: got %b, required 1", mat_valid);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (a[pos(k)] !== 8'(8'h20 + k)) begin
        errors++;
        $display("FAIL gap_a%0d%0d: got %h, required %h", pos(k)/4+1, pos(k)%4+1, a[pos(k)], 8'(8'h20 + k));
      end
    end
    mat_ack = 1'b1;
    tick();
    mat_ack = 1'b0;
  endtask

  task automatic test_clear();
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + k);
      tick();
    end
    in_data = 8'h55;
    clear   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_ready: got %b, required 0", in_ready);
    end
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (load_count !== 5'd0 || mat_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_ctrl: load_count=%0d mat_valid=%b, required 0/0", load_count, mat_valid);
    end
    for (int p = 0; p < 16; p++) begin
      checks++;
      if (a[p] !== 8'h00) begin
        errors++;
        $display("FAIL clear_a%0d%0d: got %h, required 00", p/4+1, p%4+1, a[p]);
      end
    end
    in_valid = 1'b1;
    in_data  = 8'h66;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a[pos(0)] !== 8'h66 || a[pos(1)] !== 8'h00 || load_count !== 5'd1) begin
      errors++;
      $display("FAIL clear_next: first=%h second=%h load_count=%0d, required 66/00/1",
               a[pos(0)], a[pos(1)], load_count);
    end
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + k);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (load_count !== 5'd9) begin
      errors++;
      $display("FAIL areset_pre: load_count=%0d, required 9", load_count);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (load_count !== 5'd0 || mat_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_ctrl: load_count=%0d mat_valid=%b, required 0/0", load_count, mat_valid);
    end
    for (int p = 0; p < 16; p++) begin
      checks++;
      if (a[p] !== 8'h00) begin
        errors++;
        $display("FAIL areset_a%0d%0d: got %h, required 00", p/4+1, p%4+1, a[p]);
      end
    end
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a[pos(0)] !== 8'h77 || load_count !== 5'd1) begin
      errors++;
      $display("FAIL areset_next: first=%h load_count=%0d, required 77/1", a[pos(0)], load_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_hold_and_ack();
    test_gapped();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_load_module.md
Name: matrix_load_module

Overview:
- Upstream stage for custom_input_module.
- Accepts a byte stream over a valid/ready handshake and fills a 4x4 matrix register bank, row-major by default.
- Presents the matrix as a11..a44 and raises mat_valid when all 16 elements are loaded.
- Holds the bank stable, so the downstream mux can select elements freely, until the consumer acknowledges.

Parameters:
- DATA_W, 8, width of each matrix element and of in_data.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush: zero the bank, restart the fill.
- in_data  input  DATA_W  incoming element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- mat_ack  input  1  consumer has finished with the matrix.
- mat_valid  output  1  all 16 elements are loaded and stable.
- load_count  output  5  number of elements accepted in the current fill, 0..16.
- a11..a14, a21..a24, a31..a34, a41..a44  output  DATA_W each  registered matrix elements.

Behaviour:
- Reset (async, active-high):
  - State=FILL; index=0; load_count=0.
  - All aNN=0; mat_valid=0.
  - in_ready=1 once reset is released.
- States: FILL, FULL. Encoding is held in the package.
- in_ready = (state==FILL) && !clear, combinational from registered state and clear.
- Transfer occurs on a rising edge where in_valid && in_ready.
- FILL:
  - Each transfer writes in_data to the element at index (row-major: index 0 -> a11, 1 -> a12, ..., 4 -> a21, ..., 15 -> a44), then increments index and load_count.
  - The transfer at index 15 sets state=FULL, mat_valid=1 and load_count=16 on the same edge.
  - mat_valid is therefore visible in the cycle after the 16th transfer (latency 1).
  - in_valid low: no change. mat_ack is ignored in FILL.
- FULL:
  - in_ready=0, and in_data is ignored even if in_valid=1.
  - aNN hold their values.
  - mat_ack=1 for one or more cycles: on the first edge, state=FILL, mat_valid=0, index=0, load_count=0.
  - aNN retain their old values and are overwritten element by element during the next fill.
- Back-to-back: after an ack, a transfer is possible in the very next cycle. The first byte goes to a11.
- clear (synchronous, highest priority after reset):
  - State=FILL, index=0, load_count=0, mat_valid=0, all aNN=0.
  - Overrides a simultaneous transfer (in_ready is low, so no byte is lost) and a simultaneous mat_ack.
- Mid-fill reset or clear: the partial matrix is discarded and the next transfer goes to a11.
- Index wrap: index never exceeds 15. There is no wrap into a11 without ack or clear.
- Outputs are driven only from registers, except in_ready.

Optional Feature:
- Macro: MATRIX_LOAD_COL_MAJOR_EN.
- Defined: column-major fill order.
  - index 0 -> a11, 1 -> a21, 2 -> a31, 3 -> a41, 4 -> a12, ..., 15 -> a44.
  - Implemented by swapping the two index halves before decode.
- Undefined: row-major order as above.
- Handshake, timing and counts are identical in both builds.

Decomposition:
- Package matrix_load_pkg contains:
  - DATA_W default.
  - ELEM_CNT=16 and IDX_W=4.
  - State encoding constants ST_FILL, ST_FULL.
- One natural sub-module: load_index_decoder_module.
  - Inputs: 4-bit index and write strobe.
  - Output: 16 one-hot element write enables.
  - The MATRIX_LOAD_COL_MAJOR_EN swap lives here.
- The top module holds the FSM, the counter and the 16 DATA_W registers.

Test Plan:
- Reset release then 16 consecutive transfers of 0x01..0x10 with in_valid held high:
  - a11=0x01, a14=0x04, a21=0x05, a44=0x10.
  - mat_valid=1 exactly one cycle after the 16th transfer.
  - load_count=16; in_ready=0.
- In FULL, drive in_valid=1 with in_data=0xFF for 5 cycles:
  - No element changes.
  - mat_ack pulse drops mat_valid next cycle; load_count=0; in_ready=1.
  - Next byte 0xAA lands in a11 while a12 still reads 0x02.
- Gapped stream (in_valid toggling 1,0,0,1...) of 0x20..0x2F: same positions as the contiguous case; load_count tracks accepted bytes only.
- After 7 bytes loaded, assert clear together with in_valid=1 and data 0x55:
  - All aNN=0; load_count=0; byte not accepted.
  - The next byte 0x66 goes to a11.
- Assert async reset mid-fill at index 9, off-clock-edge: all outputs zero immediately; mat_valid=0.
- Build with MATRIX_LOAD_COL_MAJOR_EN and load 0x01..0x10: a21=0x02, a41=0x04, a12=0x05, a44=0x10.
